// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the data stage.
// One request is latched at a time. Data has priority, and a streak limit keeps fetch from starving.
module mem_port_arbiter #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic [31:0]     o_if_rdata,
    output logic            o_if_valid,
    output logic            o_if_stall,
    input  logic            i_d_memread,
    input  logic            i_d_memwrite,
    input  logic [XLEN-1:0] i_d_addr,
    input  logic [XLEN-1:0] i_d_wdata,
    input  logic [2:0]      i_d_RW_type,
    output logic [XLEN-1:0] o_d_rdata,
    output logic            o_d_valid,
    output logic            o_d_stall,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [2:0]      o_mem_size,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam int unsigned SW = $clog2(MAX_STREAK) + 1;
    localparam logic [SW-1:0] MAX_S = SW'(MAX_STREAK);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;
    typedef enum logic {OwnFetch, OwnData} owner_e;

    state_e          r_state;
    owner_e          r_owner;
    logic [SW-1:0]   r_streak;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_size;
    logic            r_we;
    logic            r_mem_req;
    logic [31:0]     r_if_rdata;
    logic [XLEN-1:0] r_d_rdata;
    logic            r_if_valid;
    logic            r_d_valid;

    logic w_d_req;
    logic w_data_win;
    logic w_fetch_win;

    assign w_d_req     = i_d_memread | i_d_memwrite;
    assign w_data_win  = w_d_req && (!i_if_req || (r_streak < MAX_S));
    assign w_fetch_win = !w_data_win && i_if_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_owner    <= OwnFetch;
            r_streak   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_we       <= 1'b0;
            r_mem_req  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Streak only counts data wins that made a waiting fetch wait longer
                    if (!i_if_req || w_fetch_win) begin
                        r_streak <= '0;
                    end else if (w_data_win && (r_streak != MAX_S)) begin
                        r_streak <= r_streak + 1'b1;
                    end
                    if (w_data_win) begin
                        r_owner   <= OwnData;
                        r_addr    <= i_d_addr;
                        r_wdata   <= i_d_wdata;
                        r_size    <= i_d_RW_type;
                        r_we      <= i_d_memwrite;
                        r_mem_req <= 1'b1;
                        r_state   <= StReq;
                    end else if (w_fetch_win) begin
                        r_owner   <= OwnFetch;
                        r_addr    <= i_if_addr;
                        r_size    <= 3'b010;
                        r_we      <= 1'b0;
                        r_mem_req <= 1'b1;
                        r_state   <= StReq;
                    end
                end
                StReq: begin
                    if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= StWait;
                    end
                end
                StWait: begin
                    if (i_mem_rvalid) begin
                        if (r_owner == OwnData) begin
                            r_d_rdata <= i_mem_rdata;
                            r_d_valid <= 1'b1;
                        end else begin
                            r_if_rdata <= r_addr[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
                            r_if_valid <= 1'b1;
                        end
                        r_state <= StDone;
                    end
                end
                StDone: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = r_if_valid;
    assign o_if_stall  = i_if_req & ~r_if_valid;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_valid   = r_d_valid;
    assign o_d_stall   = w_d_req & ~r_d_valid;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_size  = r_size;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// The bench drives inputs and samples outputs on the falling clock edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_memread = 1'b0;
    logic        d_memwrite = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic [2:0]  d_rw = '0;
    logic [63:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [2:0]  mem_size;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(64), .MAX_STREAK(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .o_if_rdata   (if_rdata),
        .o_if_valid   (if_valid),
        .o_if_stall   (if_stall),
        .i_d_memread  (d_memread),
        .i_d_memwrite (d_memwrite),
        .i_d_addr     (d_addr),
        .i_d_wdata    (d_wdata),
        .i_d_RW_type  (d_rw),
        .o_d_rdata    (d_rdata),
        .o_d_valid    (d_valid),
        .o_d_stall    (d_stall),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_size   (mem_size),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called in the first REQ cycle; returns in the DONE cycle.
    task automatic serve(input int gwait, input int rwait, input logic [63:0] rd);
        repeat (gwait) step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        repeat (rwait) step();
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_size", mem_size, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        step();
        rst_n = 1'b1;
        step();

        // Single load
        d_memread = 1'b1;
        d_addr    = 64'h1000;
        d_rw      = 3'b011;
        #1 chk("load_stall_c0", d_stall, 1);
        step();
        chk("load_req_c1", mem_req, 1);
        chk("load_addr", mem_addr, 64'h1000);
        chk("load_size", mem_size, 3'b011);
        chk("load_we", mem_we, 0);
        chk("load_stall_c1", d_stall, 1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("load_req_c2", mem_req, 0);
        chk("load_stall_c2", d_stall, 1);
        chk("load_valid_c2", d_valid, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEADBEEF_CAFEF00D;
        step();
        mem_rvalid = 1'b0;
        chk("load_valid_c3", d_valid, 1);
        chk("load_rdata", d_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("load_stall_c3", d_stall, 0);
        d_memread = 1'b0;
        step();
        chk("load_valid_c4", d_valid, 0);
        chk("load_idle_req", mem_req, 0);

        // Simultaneous fetch and load: load first
        if_req    = 1'b1;
        if_addr   = 64'h2000;
        d_memread = 1'b1;
        d_addr    = 64'h3000;
        d_rw      = 3'b010;
        #1 chk("both_if_stall_c0", if_stall, 1);
        step();
        chk("both_first_addr", mem_addr, 64'h3000);
        chk("both_if_stall_c1", if_stall, 1);
        serve(0, 0, 64'h01234567_89ABCDEF);
        chk("both_d_valid", d_valid, 1);
        chk("both_if_valid_early", if_valid, 0);
        chk("both_if_stall_done", if_stall, 1);
        d_memread = 1'b0;
        step();
        chk("both_idle_req", mem_req, 0);
        chk("both_if_stall_idle", if_stall, 1);
        step();
        chk("both_fetch_req", mem_req, 1);
        chk("both_fetch_addr", mem_addr, 64'h2000);
        chk("both_fetch_size", mem_size, 3'b010);
        serve(0, 0, 64'h11111111_22222222);
        chk("both_if_valid", if_valid, 1);
        chk("fetch_lo_word", if_rdata, 64'h22222222);
        chk("both_if_stall_end", if_stall, 0);
        chk("d_rdata_held", d_rdata, 64'h01234567_89ABCDEF);
        if_req = 1'b0;
        step();

        // Fetch word select, upper half
        if_req  = 1'b1;
        if_addr = 64'h2004;
        step();
        chk("fetch_hi_addr", mem_addr, 64'h2004);
        serve(0, 0, 64'h11111111_22222222);
        chk("fetch_hi_valid", if_valid, 1);
        chk("fetch_hi_word", if_rdata, 64'h11111111);
        if_req = 1'b0;
        step();

        // Starvation guard: two rounds of 4 data then 1 fetch
        if_req    = 1'b1;
        if_addr   = 64'h4000;
        d_memread = 1'b1;
        d_addr    = 64'h5000;
        d_rw      = 3'b011;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                chk("starve_data_addr", mem_addr, 64'h5000);
                serve(0, 0, 64'(i));
                chk("starve_d_valid", d_valid, 1);
                step();
            end
            step();
            chk("starve_fetch_addr", mem_addr, 64'h4000);
            serve(0, 0, 64'h0);
            chk("starve_if_valid", if_valid, 1);
            if (r == 1) begin
                if_req    = 1'b0;
                d_memread = 1'b0;
            end
            step();
        end

        // Store with delayed grant; read+write together acts as a store
        d_memwrite = 1'b1;
        d_memread  = 1'b1;
        d_addr     = 64'h6000;
        d_wdata    = 64'h55;
        d_rw       = 3'b011;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("store_req", mem_req, 1);
            chk("store_addr", mem_addr, 64'h6000);
            chk("store_wdata", mem_wdata, 64'h55);
            chk("store_we", mem_we, 1);
            if (k == 3) mem_gnt = 1'b1;
            step();
        end
        mem_gnt = 1'b0;
        chk("store_wait_req", mem_req, 0);
        chk("store_wait_valid", d_valid, 0);
        step();
        chk("store_wait2_valid", d_valid, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0;
        step();
        mem_rvalid = 1'b0;
        chk("store_valid", d_valid, 1);
        chk("store_stall", d_stall, 0);
        d_memwrite = 1'b0;
        d_memread  = 1'b0;
        step();
        chk("store_valid_gone", d_valid, 0);

        // Reset in WAIT, then stray rvalid
        d_memread = 1'b1;
        d_addr    = 64'h7000;
        d_rw      = 3'b001;
        step();
        chk("rstw_req", mem_req, 1);
        mem_gnt = 1'b1;
        step();
        mem_gnt   = 1'b0;
        rst_n     = 1'b0;
        d_memread = 1'b0;
        #1;
        chk("rstw_mem_req", mem_req, 0);
        chk("rstw_mem_addr", mem_addr, 0);
        chk("rstw_mem_size", mem_size, 0);
        chk("rstw_d_rdata", d_rdata, 0);
        chk("rstw_if_rdata", if_rdata, 0);
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFFFFFF_FFFFFFFF;
        step();
        mem_rvalid = 1'b0;
        chk("stray_d_valid", d_valid, 0);
        chk("stray_if_valid", if_valid, 0);
        chk("stray_d_rdata", d_rdata, 0);
        step();
        chk("stray_d_valid2", d_valid, 0);
        if_req  = 1'b1;
        if_addr = 64'h2004;
        step();
        chk("post_rst_fetch_addr", mem_addr, 64'h2004);
        serve(0, 0, 64'hAAAAAAAA_BBBBBBBB);
        chk("post_rst_if_valid", if_valid, 1);
        chk("post_rst_if_rdata", if_rdata, 64'hAAAAAAAA);
        if_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
